// File: rtl/link_train_ctrl_pkg.sv
// Shared definitions for the link training controller: FSM state encoding,
// the default sync pattern and a counter-width helper.
package link_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_TRACK  = 3'd3,
        ST_FAIL   = 3'd4
    } lt_state_e;

    localparam logic [31:0] LT_DEFAULT_SYNC_WORD = 32'h0000_F731;

    // Bits needed to hold every value from 0 up to and including limit.
    function automatic int lt_cnt_width(input int unsigned limit);
        return $clog2(limit + 32'd1);
    endfunction

endpackage

// File: rtl/link_train_ctrl_timer.sv
// lt_timer: loadable up-counter with a terminal-count flag. The controller
// reloads it on every state entry and uses it for both the INIT hold time
// and the SEARCH timeout. It holds at the terminal value rather than wrap.
module lt_timer
    import link_train_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == term_i);

    // Next count: load wins over increment; stop at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/link_train_ctrl.sv
// link_train_ctrl: word-alignment training sequencer for one 32-bit lane.
// Pulses PHY_INIT, waits for ALIGNED with timeout and bounded retries, then
// tracks lock by watching the periodic sync word and retrains on loss.
// Build option: define LINK_TRAIN_STATS_EN to get a saturating 16-bit
// relock event counter on relock_cnt_o; otherwise that port is tied to 0.
module link_train_ctrl
    import link_train_pkg::*;
#(
    parameter int unsigned INIT_CYCLES    = 8,
    parameter int unsigned SEARCH_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY      = 4,
    parameter logic [31:0] SYNC_WORD      = LT_DEFAULT_SYNC_WORD,
    parameter int unsigned SYNC_PERIOD    = 256,
    parameter int unsigned LOCK_MISS      = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           aligned_i,
    input  logic                           dopush_i,
    input  logic [31:0]                    dout_i,
    output logic                           phy_init_o,
    output logic                           link_up_o,
    output logic                           link_err_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o,
    output logic [15:0]                    relock_cnt_o
);

    localparam int unsigned TMAX = (INIT_CYCLES > SEARCH_TIMEOUT) ? INIT_CYCLES : SEARCH_TIMEOUT;
    localparam int TW = lt_cnt_width(TMAX);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int WW = lt_cnt_width(SYNC_PERIOD);
    localparam int MW = lt_cnt_width(LOCK_MISS);

    localparam logic [TW-1:0] INIT_TERM   = TW'(INIT_CYCLES - 1);
    localparam logic [TW-1:0] SEARCH_TERM = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);
    localparam logic [WW-1:0] WORD_LAST   = WW'(SYNC_PERIOD - 1);
    localparam logic [MW-1:0] MISS_LAST   = MW'(LOCK_MISS - 1);

    lt_state_e     state_q, state_d;
    logic          phy_init_q, link_up_q, link_err_q;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [MW-1:0] miss_q, miss_d;

    logic          tmr_load_s;
    logic          tmr_en_s;
    logic          tmr_tc_s;
    logic [TW-1:0] tmr_term_s;
    logic          sync_hit_s;
    logic          period_end_s;

    // The timer restarts from zero whenever the FSM changes state.
    assign tmr_load_s = (state_d != state_q);
    assign tmr_en_s   = (state_q == ST_INIT) || (state_q == ST_SEARCH);
    assign tmr_term_s = (state_q == ST_INIT) ? INIT_TERM : SEARCH_TERM;

    // A sync word on the push that closes a period counts as found.
    assign sync_hit_s   = dopush_i && (dout_i == SYNC_WORD);
    assign period_end_s = dopush_i && !sync_hit_s && (wcnt_q == WORD_LAST);

    lt_timer #(
        .W (TW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load_s),
        .load_val_i ({TW{1'b0}}),
        .en_i       (tmr_en_s),
        .term_i     (tmr_term_s),
        .tc_o       (tmr_tc_s)
    );

    // Next-state, retry bookkeeping and sync-tracking counters.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        wcnt_d  = wcnt_q;
        miss_d  = miss_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INIT: begin
                // ALIGNED is meaningless while the aligner is being cleared.
                if (tmr_tc_s) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_SEARCH: begin
                if (aligned_i) begin
                    state_d = ST_TRACK;
                end else if (tmr_tc_s) begin
                    retry_d = retry_q + RW'(1);
                    if (retry_q == RETRY_LAST) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_INIT;
                    end
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_TRACK: begin
                if (!aligned_i || (period_end_s && (miss_q == MISS_LAST))) begin
                    retry_d = '0;
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_TRACK;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping START aborts from anywhere without counting anything.
        if (!start_i) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end

        if (state_d == ST_IDLE) begin
            retry_d = '0;
        end else begin
            retry_d = retry_d;
        end

        // Word/miss counters only live while tracking; zero on entry.
        if (state_d != ST_TRACK) begin
            wcnt_d = '0;
            miss_d = '0;
        end else if (sync_hit_s) begin
            wcnt_d = '0;
            miss_d = '0;
        end else if (period_end_s) begin
            wcnt_d = '0;
            miss_d = miss_q + MW'(1);
        end else if (dopush_i) begin
            wcnt_d = wcnt_q + WW'(1);
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    // State, counters and outputs decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            retry_q    <= '0;
            wcnt_q     <= '0;
            miss_q     <= '0;
            phy_init_q <= 1'b0;
            link_up_q  <= 1'b0;
            link_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            wcnt_q     <= wcnt_d;
            miss_q     <= miss_d;
            phy_init_q <= (state_d == ST_INIT);
            link_up_q  <= (state_d == ST_TRACK);
            link_err_q <= (state_d == ST_FAIL);
        end
    end

    assign phy_init_o  = phy_init_q;
    assign link_up_o   = link_up_q;
    assign link_err_o  = link_err_q;
    assign retry_cnt_o = retry_q;

`ifdef LINK_TRAIN_STATS_EN
    logic        relock_inc_s;
    logic [15:0] relock_q;

    assign relock_inc_s = (state_q == ST_TRACK) && (state_d == ST_INIT);

    // Saturating count of loss-of-lock events; only RST clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            relock_q <= 16'd0;
        end else if (relock_inc_s && (relock_q != 16'hFFFF)) begin
            relock_q <= relock_q + 16'd1;
        end else begin
            relock_q <= relock_q;
        end
    end

    assign relock_cnt_o = relock_q;
`else
    assign relock_cnt_o = 16'd0;
`endif

endmodule
